// File: rtl/rdb_entry_scheduler.sv
// RDB entry scheduler: allocates read-data-buffer entries, issues SRAM reads,
// strobes RDB writes after the SRAM latency and drains entries in order.
module rdb_entry_scheduler #(
  parameter int ENTRY_NUM       = 16,
  parameter int ENTRY_ID_WIDTH  = $clog2(ENTRY_NUM),
  parameter int TXN_ID_WIDTH    = 8,
  parameter int READ_SRAM_DELAY = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_vld,
  input  logic [TXN_ID_WIDTH-1:0]   req_txn_id,
  output logic                      req_rdy,
  output logic                      sram_rd_vld,
  output logic [ENTRY_ID_WIDTH-1:0] sram_rd_idx,
  output logic                      rdb_wr_en,
  output logic [ENTRY_ID_WIDTH-1:0] rdb_wr_addr,
  output logic                      us_vld,
  output logic [ENTRY_ID_WIDTH-1:0] us_idx,
  output logic [TXN_ID_WIDTH-1:0]   us_txn_id,
  input  logic                      us_rdy,
  output logic                      rdb_rd_en,
  output logic                      done_vld,
  output logic [ENTRY_ID_WIDTH-1:0] done_idx,
  output logic [ENTRY_ID_WIDTH:0]   occupancy,
  output logic                      err
);

  localparam int W = ENTRY_ID_WIDTH;
  localparam int D = READ_SRAM_DELAY;

  typedef logic [W-1:0]            idx_t;
  typedef logic [TXN_ID_WIDTH-1:0] txn_t;
  typedef logic [W:0]              cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(ENTRY_NUM);

  typedef enum logic [1:0] {
    E_FREE = 2'd0,
    E_PEND = 2'd1,
    E_RDY  = 2'd2
  } ent_e;

  ent_e state_q [ENTRY_NUM];
  ent_e state_d [ENTRY_NUM];
  txn_t txn_q   [ENTRY_NUM];
  txn_t txn_d   [ENTRY_NUM];
  idx_t ord_q   [ENTRY_NUM];
  idx_t ord_d   [ENTRY_NUM];

  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t occ_q, occ_d;

  logic sram_vld_q, sram_vld_d;
  idx_t sram_idx_q, sram_idx_d;

  logic [D-1:0]        pipe_vld_q, pipe_vld_d;
  logic [D-1:0][W-1:0] pipe_idx_q, pipe_idx_d;

  logic done_vld_q, done_vld_d;
  idx_t done_idx_q, done_idx_d;
  logic err_q, err_d;

  logic full;
  logic empty;
  logic found;
  logic accept;
  logic hs;
  logic wr_en;
  idx_t alloc_idx;
  idx_t head_idx;
  idx_t wr_addr;

  assign full     = (occ_q == FULL_CNT);
  assign empty    = (occ_q == '0);
  assign req_rdy  = !full;
  assign accept   = req_vld && req_rdy;
  assign head_idx = ord_q[head_q];
  assign wr_en    = pipe_vld_q[D-1];
  assign wr_addr  = pipe_idx_q[D-1];
  assign us_vld   = !empty && (state_q[head_idx] == E_RDY);
  assign hs       = us_vld && us_rdy;

  assign sram_rd_vld = sram_vld_q;
  assign sram_rd_idx = sram_idx_q;
  assign rdb_wr_en   = wr_en;
  assign rdb_wr_addr = wr_addr;
  assign us_idx      = head_idx;
  assign us_txn_id   = txn_q[head_idx];
  assign rdb_rd_en   = hs;
  assign done_vld    = done_vld_q;
  assign done_idx    = done_idx_q;
  assign occupancy   = occ_q;
  assign err         = err_q;

  // Lowest-index FREE entry from the registered state (no same-cycle reuse)
  always_comb begin
    found     = 1'b0;
    alloc_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!found && state_q[i] == E_FREE) begin
        found     = 1'b1;
        alloc_idx = idx_t'(i);
      end
    end
  end

  // Next-state: entry states, order queue, counters, latency pipe, error
  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    ord_d      = ord_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    sram_vld_d = accept;
    sram_idx_d = accept ? alloc_idx : '0;
    done_vld_d = hs;
    done_idx_d = hs ? head_idx : '0;
    pipe_vld_d = '0;
    pipe_idx_d = '0;
    err_d      = err_q;

    if (wr_en && state_q[wr_addr] == E_PEND) begin
      state_d[wr_addr] = E_RDY;
    end
    if (wr_en && state_q[wr_addr] != E_PEND) begin
      err_d = 1'b1;
    end

    if (hs) begin
      state_d[head_idx] = E_FREE;
      head_d            = head_q + 1'b1;
    end

    if (accept) begin
      state_d[alloc_idx] = E_PEND;
      txn_d[alloc_idx]   = req_txn_id;
      ord_d[tail_q]      = alloc_idx;
      tail_d             = tail_q + 1'b1;
      if (full) begin
        err_d = 1'b1;
      end
    end

    unique case ({accept, hs})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    pipe_vld_d[0] = sram_vld_q;
    pipe_idx_d[0] = sram_idx_q;
    for (int i = 1; i < D; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
  end

  // State registers; reset discards all in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state_q[i] <= E_FREE;
        txn_q[i]   <= '0;
        ord_q[i]   <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      sram_vld_q <= 1'b0;
      sram_idx_q <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
      done_vld_q <= 1'b0;
      done_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      ord_q      <= ord_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      sram_vld_q <= sram_vld_d;
      sram_idx_q <= sram_idx_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
      done_vld_q <= done_vld_d;
      done_idx_q <= done_idx_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_rdb_entry_scheduler.sv
// Randomized scoreboard bench for rdb_entry_scheduler.
// A cycle-level reference model predicts every strobe and handshake.
module tb_rdb_entry_scheduler;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int TW = 8;
  localparam int D  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_vld = 1'b0;
  logic [TW-1:0] req_txn_id = '0;
  logic          req_rdy;
  logic          sram_rd_vld;
  logic [W-1:0]  sram_rd_idx;
  logic          rdb_wr_en;
  logic [W-1:0]  rdb_wr_addr;
  logic          us_vld;
  logic [W-1:0]  us_idx;
  logic [TW-1:0] us_txn_id;
  logic          us_rdy = 1'b0;
  logic          rdb_rd_en;
  logic          done_vld;
  logic [W-1:0]  done_idx;
  logic [W:0]    occupancy;
  logic          err;

  rdb_entry_scheduler #(
    .ENTRY_NUM(N),
    .TXN_ID_WIDTH(TW),
    .READ_SRAM_DELAY(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_vld(req_vld),
    .req_txn_id(req_txn_id),
    .req_rdy(req_rdy),
    .sram_rd_vld(sram_rd_vld),
    .sram_rd_idx(sram_rd_idx),
    .rdb_wr_en(rdb_wr_en),
    .rdb_wr_addr(rdb_wr_addr),
    .us_vld(us_vld),
    .us_idx(us_idx),
    .us_txn_id(us_txn_id),
    .us_rdy(us_rdy),
    .rdb_rd_en(rdb_rd_en),
    .done_vld(done_vld),
    .done_idx(done_idx),
    .occupancy(occupancy),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [TW-1:0] txn;
    int            cyc;
  } ent_t;

  typedef struct {
    int idx;
    int cyc;
  } ev_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   chk_en = 0;

  bit   free_m [N];
  ent_t ord_m [$];
  int   occ_m;

  ev_t  exp_sram [$];
  ev_t  exp_wr [$];
  ev_t  exp_done [$];
  ent_t exp_us [$];

  bit   mdl_rdy;
  bit   mdl_usvld;
  int   mdl_occ;

  bit        prev_hold = 0;
  logic [W-1:0] prev_idx;

  localparam logic [D-1:0] STRAY = {1'b1, {(D-1){1'b0}}};

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic chk_ev(input string nm, input logic v, input int idx,
                        ref ev_t q[$]);
    ev_t e;
    if (v) begin
      if (q.size() == 0) begin
        chk({nm, " unexpected"}, 64'(v), 64'd0);
      end else begin
        e = q.pop_front();
        chk({nm, " idx"}, 64'(idx), 64'(e.idx));
        chk({nm, " cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk({nm, " missing"}, 64'(v), 64'd1);
    end
  endtask

  task automatic model_clear();
    foreach (free_m[i]) free_m[i] = 1'b1;
    ord_m.delete();
    occ_m = 0;
    exp_sram.delete();
    exp_wr.delete();
    exp_done.delete();
    exp_us.delete();
  endtask

  // One clock cycle: drive inputs, publish predictions, advance the model
  task automatic cycle(input bit rv, input logic [TW-1:0] tx, input bit ur);
    int   idx;
    bit   acc;
    bit   hs;
    ent_t e;
    req_vld    = rv;
    req_txn_id = tx;
    us_rdy     = ur;
    mdl_rdy    = (occ_m < N);
    mdl_occ    = occ_m;
    mdl_usvld  = (ord_m.size() > 0) && (ord_m[0].cyc <= cyc);
    @(posedge clk);
    acc = rv && mdl_rdy;
    hs  = ur && mdl_usvld;
    idx = -1;
    for (int i = N - 1; i >= 0; i--) if (free_m[i]) idx = i;
    if (hs) begin
      e = ord_m.pop_front();
      free_m[e.idx] = 1'b1;
      occ_m--;
      exp_done.push_back('{e.idx, cyc + 1});
    end
    if (acc) begin
      free_m[idx] = 1'b0;
      occ_m++;
      ord_m.push_back('{idx, tx, cyc + 2 + D});
      exp_sram.push_back('{idx, cyc + 1});
      exp_wr.push_back('{idx, cyc + 1 + D});
      exp_us.push_back('{idx, tx, 0});
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    chk_en     = 0;
    rst        = 1'b1;
    req_vld    = 1'b0;
    us_rdy     = 1'b0;
    req_txn_id = '0;
    model_clear();
    #1;
    chk("rst sram_rd_vld", 64'(sram_rd_vld), 64'd0);
    chk("rst rdb_wr_en", 64'(rdb_wr_en), 64'd0);
    chk("rst us_vld", 64'(us_vld), 64'd0);
    chk("rst us_idx", 64'(us_idx), 64'd0);
    chk("rst us_txn_id", 64'(us_txn_id), 64'd0);
    chk("rst done_vld", 64'(done_vld), 64'd0);
    chk("rst occupancy", 64'(occupancy), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    repeat (n) @(posedge clk);
    cyc += n;
    #1;
    rst    = 1'b0;
    chk_en = 1;
  endtask

  // Monitor: compares every DUT output against the scoreboard
  always @(negedge clk) begin
    ent_t u;
    if (chk_en && !rst) begin
      chk("req_rdy", 64'(req_rdy), 64'(mdl_rdy));
      chk("occupancy", 64'(occupancy), 64'(mdl_occ));
      chk("us_vld", 64'(us_vld), 64'(mdl_usvld));
      chk("err", 64'(err), 64'd0);
      chk("rdb_rd_en", 64'(rdb_rd_en), 64'(us_vld && us_rdy));
      chk_ev("sram_rd", sram_rd_vld, int'(sram_rd_idx), exp_sram);
      chk_ev("rdb_wr", rdb_wr_en, int'(rdb_wr_addr), exp_wr);
      chk_ev("done", done_vld, int'(done_idx), exp_done);
      if (prev_hold) begin
        chk("us_vld hold", 64'(us_vld), 64'd1);
        chk("us_idx hold", 64'(us_idx), 64'(prev_idx));
      end
      if (us_vld && us_rdy) begin
        if (exp_us.size() == 0) begin
          chk("us unexpected", 64'(us_vld), 64'd0);
        end else begin
          u = exp_us.pop_front();
          chk("us_idx", 64'(us_idx), 64'(u.idx));
          chk("us_txn_id", 64'(us_txn_id), 64'(u.txn));
        end
      end
      prev_hold = us_vld && !us_rdy;
      prev_idx  = us_idx;
    end else begin
      prev_hold = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset(3);
    repeat (2) cycle(0, '0, 1);

    // single request into an idle block
    cycle(1, 8'h5A, 1);
    repeat (D + 6) cycle(0, '0, 1);

    // fill all entries with the US side stalled, then hold a 17th
    for (int i = 0; i < N; i++) cycle(1, 8'(i + 16), 0);
    repeat (D + 4) cycle(1, 8'hC3, 0);
    chk("full req_rdy", 64'(req_rdy), 64'd0);
    chk("full occupancy", 64'(occupancy), 64'(N));

    // single US pulse frees entry 0; held request reuses it next cycle
    cycle(1, 8'hC3, 1);
    repeat (3) cycle(1, 8'hC3, 0);
    repeat (D + 40) cycle(0, '0, 1);

    // streaming
    for (int i = 0; i < 100; i++) begin
      cycle(1, 8'($urandom), 1);
      if (i == 60)
        chk("stream occupancy range",
            64'(occupancy >= 11 && occupancy <= 12), 64'd1);
    end
    repeat (D + 20) cycle(0, '0, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
    for (int i = 0; i < 300; i++)
      cycle(1, 8'($urandom), ($urandom % 4) == 0);
    repeat (N * 2 + D + 20) cycle(0, '0, 1);

    // reset with five reads in flight
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0);
    repeat (2) cycle(0, '0, 0);
    do_reset(2);
    repeat (D + 5) cycle(0, '0, 1);
    chk("post-rst occupancy", 64'(occupancy), 64'd0);
    cycle(1, 8'h33, 1);
    repeat (D + 6) cycle(0, '0, 1);

    // stray RDB write onto a FREE entry
    repeat (2) cycle(0, '0, 0);
    chk_en = 0;
    force dut.pipe_vld_q = STRAY;
    force dut.pipe_idx_q = '0;
    cycle(0, '0, 0);
    release dut.pipe_vld_q;
    release dut.pipe_idx_q;
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 0);
      chk("err sticky", 64'(err), 64'd1);
    end
    do_reset(2);
    chk("err cleared", 64'(err), 64'd0);
    repeat (4) cycle(0, '0, 1);

    chk("leftover sram", 64'(exp_sram.size()), 64'd0);
    chk("leftover wr", 64'(exp_wr.size()), 64'd0);
    chk("leftover us", 64'(exp_us.size()), 64'd0);
    chk("leftover done", 64'(exp_done.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
